vga_im_reader: RTL and testbench
================================

VGA_IM_READER -- requirements
Module: vga_im_reader

Interface
REQ-001 Parameter IM_ADDR_W, default 15, image-memory word address width.
REQ-002 Parameter IM_DATA_W, default 8, pixel width (one pixel per memory word).
REQ-003 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in clk cycles.
REQ-004 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-005 Parameter SCALE_LOG2, default 2, pixel-replication factor 2^SCALE_LOG2; IMG_W = H_ACTIVE>>SCALE_LOG2 (derived localparam).
REQ-006 clk  input  1  single clock, equal to the pixel clock.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 en  input  1  request to scan frames.
REQ-009 im_r_en  output  1  image-memory read enable.
REQ-010 im_r_addr  output  IM_ADDR_W  image-memory read address.
REQ-011 im_r_data  input  IM_DATA_W  read data, valid exactly one cycle after im_r_en/im_r_addr are sampled.
REQ-012 hsync, vsync  output  1 each  sync pulses, active-low.
REQ-013 de  output  1  display-enable (active video).
REQ-014 rgb  output  IM_DATA_W  pixel to VGA DAC.
REQ-015 frame_start  output  1  one-cycle pulse on the first active pixel of each frame.
REQ-016 busy  output  1  high while scanning or draining the pipeline.

Function
REQ-017 h_cnt counts 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1; each line/frame is ordered active, front porch, sync, back porch.
REQ-018 FSM states: IDLE, RUN, STOPPING; counters held at (0,0) in IDLE and advance every cycle in RUN and STOPPING.
REQ-019 IDLE -> RUN on the edge sampling en=1; the first RUN cycle has counters (0,0).
REQ-020 RUN -> STOPPING on the edge sampling en=0; STOPPING -> IDLE after the cycle with counters (H_TOTAL-1, V_TOTAL-1); STOPPING -> RUN on en=1 with no counter discontinuity.
REQ-021 Stage 1 (registered, one cycle after counters): im_r_en=1 iff counters are in active area; im_r_addr=(v_cnt>>SCALE_LOG2)*IMG_W+(h_cnt>>SCALE_LOG2); im_r_addr=0 when im_r_en=0.
REQ-022 Address is formed with a row-base accumulator (add IMG_W every 2^SCALE_LOG2 active lines, clear at frame wrap) plus a column counter; no multiplier.
REQ-023 Stage 2: memory data; stage 3 (registered): rgb=im_r_data when delayed de=1, else 0.
REQ-024 hsync, vsync, de and frame_start are delayed through the same pipeline; all reach the outputs 3 cycles after the counter value producing them.
REQ-025 hsync=0 iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync=0 iff v_cnt in the corresponding vertical range, for the whole line.
REQ-026 busy=1 when state!=IDLE or any pipeline stage holds a valid-flagged entry; busy falls 3 cycles after STOPPING -> IDLE.
REQ-027 In IDLE with an empty pipeline, outputs hold their reset values.

Reset
REQ-028 rst=0 at an edge forces next cycle: state IDLE, counters 0, accumulators 0, pipeline flushed, im_r_en=0, im_r_addr=0, hsync=1, vsync=1, de=0, rgb=0, frame_start=0, busy=0.
REQ-029 Reset mid-frame aborts the frame; no partial-frame outputs after reset; with en=1 after reset release, scanning restarts at (0,0).

Structure
REQ-030 Default timing values are defined in a shared header vga_timing.vh; IM_ADDR_W/IM_DATA_W defaults come from system.vh.
REQ-031 Counters and raw sync/de generation are in the sub-module vga_timing_gen; the top level adds FSM, address generation and the 3-stage alignment pipeline.

Verification (params H 8/2/2/2, V 4/1/1/1, SCALE_LOG2=1, IMG_W=4; memory model returns data=addr, registered, 1 cycle)
REQ-032 en=1 after reset -> im_r_addr over active lines 0..3: 0,0,1,1,2,2,3,3 / same / 4,4,5,5,6,6,7,7 / same; rgb mirrors that sequence 2 cycles after each address, de high 8 cycles per line.
REQ-033 Continuous run -> hsync low exactly 2 cycles per 14-cycle line; vsync low exactly 14 cycles per 98-cycle frame; frame_start every 98 cycles, coincident with first de.
REQ-034 en dropped at counters (3,1) -> frame completes through (13,6), state IDLE, busy falls 3 cycles later, no further frame_start.
REQ-035 en dropped then re-raised within the same frame -> next frame starts without gap; frame_start spacing stays 98.
REQ-036 rst=0 at (5,2) -> next cycle all REQ-028 values; with en=1 after release, first de 4 cycles after release with rgb=0.
REQ-037 Memory model forced to 0xFF always -> rgb=0 whenever de=0 (porches, sync, vertical blank).

Source files
------------

// File: rtl/vga_im_reader_pkg.sv
// Shared defaults, FSM state type and pipeline entry type for the VGA image-memory reader.
package vga_im_reader_pkg;

  localparam int unsigned IM_ADDR_W_DEF  = 15;
  localparam int unsigned IM_DATA_W_DEF  = 8;
  localparam int unsigned H_ACTIVE_DEF   = 640;
  localparam int unsigned H_FP_DEF       = 16;
  localparam int unsigned H_SYNC_DEF     = 96;
  localparam int unsigned H_BP_DEF       = 48;
  localparam int unsigned V_ACTIVE_DEF   = 480;
  localparam int unsigned V_FP_DEF       = 10;
  localparam int unsigned V_SYNC_DEF     = 2;
  localparam int unsigned V_BP_DEF       = 33;
  localparam int unsigned SCALE_LOG2_DEF = 2;

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  // Control flags carried alongside the memory access so video timing stays aligned with rgb.
  typedef struct packed {
    logic valid;
    logic de;
    logic hsync;
    logic vsync;
    logic fstart;
  } pipe_t;

  localparam pipe_t PipeIdle = '{valid: 1'b0, de: 1'b0, hsync: 1'b1, vsync: 1'b1, fstart: 1'b0};

  function automatic logic in_window(int unsigned pos, int unsigned lo, int unsigned len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_im_reader_if.sv
// Image-memory read port: address/enable out, data back one cycle later.
interface vga_im_reader_if import vga_im_reader_pkg::*; #(
  parameter int unsigned IM_ADDR_W = IM_ADDR_W_DEF,
  parameter int unsigned IM_DATA_W = IM_DATA_W_DEF
) ();

  logic                 im_r_en;
  logic [IM_ADDR_W-1:0] im_r_addr;
  logic [IM_DATA_W-1:0] im_r_data;

  modport master (output im_r_en, output im_r_addr, input im_r_data);
  modport slave  (input im_r_en, input im_r_addr, output im_r_data);

endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters with raw (unpipelined) sync, display-enable and frame flags.
module vga_timing_gen import vga_im_reader_pkg::*; #(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned H_CNT_W  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int unsigned V_CNT_W  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               line_end,
  output logic               frame_end,
  output logic               de_raw,
  output logic               hsync_raw,
  output logic               vsync_raw,
  output logic               frame_first
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;

  assign line_end  = h_cnt_q == H_CNT_W'(H_TOTAL - 1);
  assign frame_end = line_end && (v_cnt_q == V_CNT_W'(V_TOTAL - 1));

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (advance) begin
      if (line_end) begin
        h_cnt_d = '0;
        v_cnt_d = frame_end ? '0 : v_cnt_q + V_CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + H_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign de_raw      = in_window(32'(h_cnt_q), 0, H_ACTIVE) && in_window(32'(v_cnt_q), 0, V_ACTIVE);
  assign hsync_raw   = !in_window(32'(h_cnt_q), H_ACTIVE + H_FP, H_SYNC);
  assign vsync_raw   = !in_window(32'(v_cnt_q), V_ACTIVE + V_FP, V_SYNC);
  assign frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_im_reader.sv
// Scans an image memory in VGA raster order with pixel replication; three-stage aligned output.
module vga_im_reader import vga_im_reader_pkg::*; #(
  parameter int unsigned IM_ADDR_W  = IM_ADDR_W_DEF,
  parameter int unsigned IM_DATA_W  = IM_DATA_W_DEF,
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned SCALE_LOG2 = SCALE_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  vga_im_reader_if.master      mem,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [IM_DATA_W-1:0] rgb,
  output logic                 frame_start,
  output logic                 busy
);

  localparam int unsigned H_CNT_W  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned V_CNT_W  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int unsigned IMG_W    = H_ACTIVE >> SCALE_LOG2;
  localparam int unsigned SUB_MASK = (32'd1 << SCALE_LOG2) - 32'd1;

  state_e               state_q, state_d;
  logic                 scan;
  logic [H_CNT_W-1:0]   h_cnt;
  logic [V_CNT_W-1:0]   v_cnt;
  logic                 line_end, frame_end, de_raw, hsync_raw, vsync_raw, frame_first;
  logic                 v_active, sub_last;
  logic [IM_ADDR_W-1:0] row_base_q, row_base_d, col;
  logic                 r_en_q;
  logic [IM_ADDR_W-1:0] r_addr_q;
  logic [IM_DATA_W-1:0] rgb_q;
  pipe_t                p0, p1_q, p2_q, p3_q;

  assign scan = state_q != StIdle;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_CNT_W  (H_CNT_W),
    .V_CNT_W  (V_CNT_W)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .advance     (scan),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .de_raw      (de_raw),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .frame_first (frame_first)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (en) state_d = StRun;
      StRun:      if (!en) state_d = StStopping;
      StStopping: begin
        if (en)             state_d = StRun;
        else if (frame_end) state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase
  end

  // Row base steps by one image row after the last replicated copy of each active line.
  assign v_active = in_window(32'(v_cnt), 0, V_ACTIVE);
  assign sub_last = (v_cnt & V_CNT_W'(SUB_MASK)) == V_CNT_W'(SUB_MASK);
  assign col      = IM_ADDR_W'(h_cnt >> SCALE_LOG2);

  always_comb begin
    row_base_d = row_base_q;
    if (scan && line_end) begin
      if (frame_end)                 row_base_d = '0;
      else if (v_active && sub_last) row_base_d = row_base_q + IM_ADDR_W'(IMG_W);
    end
  end

  always_comb begin
    p0 = PipeIdle;
    if (scan) begin
      p0.valid  = 1'b1;
      p0.de     = de_raw;
      p0.hsync  = hsync_raw;
      p0.vsync  = vsync_raw;
      p0.fstart = frame_first;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      row_base_q <= '0;
      p1_q       <= PipeIdle;
      p2_q       <= PipeIdle;
      p3_q       <= PipeIdle;
      r_en_q     <= 1'b0;
      r_addr_q   <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
      p1_q       <= p0;
      p2_q       <= p1_q;
      p3_q       <= p2_q;
      r_en_q     <= p0.de;
      r_addr_q   <= p0.de ? row_base_q + col : '0;
      rgb_q      <= p2_q.de ? mem.im_r_data : '0;
    end
  end

  assign mem.im_r_en   = r_en_q;
  assign mem.im_r_addr = r_addr_q;
  assign hsync         = p3_q.hsync;
  assign vsync         = p3_q.vsync;
  assign de            = p3_q.de;
  assign frame_start   = p3_q.fstart;
  assign rgb           = rgb_q;
  assign busy          = scan | p1_q.valid | p2_q.valid | p3_q.valid;

endmodule

// File: tb/tb_vga_im_reader.sv
// Bench for vga_im_reader: raster-position reference model, directed scenarios, random en/rst.
module tb_vga_im_reader;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int SL = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int IW = HA >> SL;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          ff_mode = 1'b0;
  logic          hsync, vsync, de, frame_start, busy;
  logic [DW-1:0] rgb;

  vga_im_reader_if #(.IM_ADDR_W(AW), .IM_DATA_W(DW)) mif ();

  vga_im_reader #(
    .IM_ADDR_W  (AW),
    .IM_DATA_W  (DW),
    .H_ACTIVE   (HA),
    .H_FP       (HF),
    .H_SYNC     (HS),
    .H_BP       (HB),
    .V_ACTIVE   (VA),
    .V_FP       (VF),
    .V_SYNC     (VS),
    .V_BP       (VB),
    .SCALE_LOG2 (SL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mem         (mif),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Registered memory: data equals address unless forced to all-ones.
  always @(posedge clk) mif.im_r_data <= ff_mode ? 8'hFF : mif.im_r_addr[DW-1:0];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: scan position plus a three-deep delay line of expected outputs.
  typedef struct {
    bit valid;
    bit de;
    bit hs;
    bit vs;
    bit fs;
    int addr;
    int data;
  } ent_t;

  function automatic ent_t idle_ent();
    ent_t e;
    e.valid = 0; e.de = 0; e.hs = 1; e.vs = 1; e.fs = 0; e.addr = 0; e.data = 0;
    return e;
  endfunction

  bit   m_scan = 0;
  bit   m_stop = 0;
  int   m_pos = 0;
  ent_t st1 = idle_ent();
  ent_t st2 = idle_ent();
  ent_t st3 = idle_ent();

  initial begin
    forever begin
      ent_t e;
      int   h, v;
      bit   last;
      @(posedge clk);
      if (!rst) begin
        m_scan = 0; m_stop = 0; m_pos = 0;
        st1 = idle_ent(); st2 = idle_ent(); st3 = idle_ent();
      end else begin
        e = idle_ent();
        if (m_scan) begin
          h = m_pos % HT;
          v = m_pos / HT;
          e.valid = 1;
          e.de    = (h < HA) && (v < VA);
          e.hs    = !((h >= HA + HF) && (h < HA + HF + HS));
          e.vs    = !((v >= VA + VF) && (v < VA + VF + VS));
          e.fs    = (m_pos == 0);
          e.addr  = e.de ? (v >> SL) * IW + (h >> SL) : 0;
        end
        st3 = st2;
        st2 = st1;
        st2.data = ff_mode ? 255 : (st1.addr & 255);
        st1 = e;
        if (!m_scan) begin
          if (en) m_scan = 1;
        end else begin
          last  = (m_pos == FT - 1);
          m_pos = (m_pos + 1) % FT;
          if (en) m_stop = 0;
          else if (!m_stop) m_stop = 1;
          else if (last) begin m_scan = 0; m_stop = 0; end
        end
      end
    end
  end

  bit chk_en = 0;
  bit cap = 0;
  bit ff_win = 0;
  int cyc = 0;
  int fs_cnt = 0, fs_last = -1, fs_gap = 0, fs_nde = 0;
  int hs_low = 0, vs_low = 0;
  int ff_blank_bad = 0, ff_act_bad = 0, ff_de_cnt = 0;
  int addr_q[$], rgb_q[$], maddr_q[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        chk("im_r_en", mif.im_r_en, st1.de);
        chk("im_r_addr", mif.im_r_addr, st1.addr);
        chk("hsync", hsync, st3.hs);
        chk("vsync", vsync, st3.vs);
        chk("de", de, st3.de);
        chk("frame_start", frame_start, st3.fs);
        chk("rgb", rgb, st3.de ? st3.data : 0);
        chk("busy", busy, m_scan | st1.valid | st2.valid | st3.valid);
      end
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_last >= 0) fs_gap = cyc - fs_last;
        fs_last = cyc;
        if (de !== 1'b1) fs_nde++;
      end
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if (cap) begin
        if (mif.im_r_en === 1'b1) addr_q.push_back(int'(mif.im_r_addr));
        if (de === 1'b1) rgb_q.push_back(int'(rgb));
        if (st1.de) maddr_q.push_back(st1.addr);
      end
      if (ff_win) begin
        if (de !== 1'b1 && rgb !== 8'h00) ff_blank_bad++;
        if (de === 1'b1) begin
          ff_de_cnt++;
          if (rgb !== 8'hFF) ff_act_bad++;
        end
      end
    end
  end

  task automatic wait_pos(input int p, input string nm);
    int n;
    n = 0;
    while (!(m_scan && m_pos == p) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, (m_scan && m_pos == p), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int row_lit[16] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7};
    int s_hs, s_vs, s_fs, n, e;

    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {busy, de, frame_start, mif.im_r_en, hsync, vsync}, 6'b000011);
    chk("reset_rgb_addr", {rgb, mif.im_r_addr}, 0);

    // First frame after start: address and pixel order
    cap = 1; rst = 1; en = 1;
    repeat (98) @(negedge clk);
    cap = 0;
    chk("addr_seq_len", addr_q.size(), 32);
    chk("rgb_seq_len", rgb_q.size(), 32);
    chk("model_seq_len", maddr_q.size(), 32);
    for (int i = 0; i < 32; i++) begin
      e = row_lit[(i / 16) * 8 + (i % 8)];
      chk($sformatf("addr_seq[%0d]", i), (addr_q.size() > i) ? addr_q[i] : -1, e);
      chk($sformatf("rgb_seq[%0d]", i), (rgb_q.size() > i) ? rgb_q[i] : -1, e);
      chk($sformatf("model_seq[%0d]", i), (maddr_q.size() > i) ? maddr_q[i] : -1, e);
    end

    // Continuous run: sync pulse widths and frame_start spacing
    s_hs = hs_low; s_vs = vs_low; s_fs = fs_cnt;
    repeat (FT) @(negedge clk);
    chk("hsync_low_per_frame", hs_low - s_hs, 14);
    chk("vsync_low_per_frame", vs_low - s_vs, 14);
    chk("fs_per_frame", fs_cnt - s_fs, 1);
    chk("fs_gap", fs_gap, 98);
    chk("fs_without_de", fs_nde, 0);

    // Drop en mid-frame: frame completes, busy falls after the pipeline drains
    wait_pos(1 * HT + 3, "reach_3_1");
    en = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 200);
    chk("stop_busy_fall_cycles", n, 84);
    s_fs = fs_cnt;
    repeat (120) @(negedge clk);
    chk("no_fs_after_stop", fs_cnt - s_fs, 0);
    chk("idle_busy", busy, 0);

    // Drop and re-raise en inside one frame: no gap
    en = 1;
    wait_pos(20, "reach_pos20");
    en = 0;
    repeat (10) @(negedge clk);
    en = 1;
    s_fs = fs_cnt;
    n = 0;
    while (fs_cnt == s_fs && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reraise_fs_seen", fs_cnt - s_fs, 1);
    chk("reraise_fs_gap", fs_gap, 98);

    // Reset mid-frame at (5,2)
    wait_pos(2 * HT + 5, "reach_5_2");
    rst = 0;
    @(negedge clk);
    chk("midreset_ctl", {busy, de, frame_start, mif.im_r_en, hsync, vsync}, 6'b000011);
    chk("midreset_rgb_addr", {rgb, mif.im_r_addr}, 0);
    rst = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (de !== 1'b1 && n < 20);
    chk("restart_first_de", n, 4);
    chk("restart_first_rgb", rgb, 0);

    // Memory forced to 0xFF: blanking must still output zero
    ff_mode = 1;
    repeat (4) @(negedge clk);
    ff_win = 1;
    repeat (FT) @(negedge clk);
    ff_win = 0;
    ff_mode = 0;
    chk("ff_blank_nonzero", ff_blank_bad, 0);
    chk("ff_active_not_ff", ff_act_bad, 0);
    chk("ff_de_cycles", ff_de_cnt, 32);

    // Randomized en / reset / memory-pattern traffic
    for (int seg = 0; seg < 90; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1;
      end
      en = 1'($urandom_range(0, 1));
      ff_mode = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end

    en = 0; rst = 1; ff_mode = 0;
    n = 0;
    while (busy !== 1'b0 && n < 250) begin
      @(negedge clk);
      n++;
    end
    chk("final_idle", busy, 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
